// File: rtl/clk_div_pkg.sv
// Shared constants and the divisor clamp helper for the programmable clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_MIN     = 2;
  localparam int CLK_DIV_WIDTH   = 16;
  localparam int CLK_DIV_DEFAULT = 4;

  // True when a requested divisor must be raised to the minimum ratio.
  function automatic logic clamp_needed(input logic [31:0] div);
    return (div < 32'(CLK_DIV_MIN));
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow divisor register with valid/ready handshake; released by the counter's apply strobe.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int WIDTH = CLK_DIV_WIDTH
) (
  input  logic             original_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  input  logic             apply,
  output logic             div_ready,
  output logic             pending,
  output logic [WIDTH-1:0] shadow_div
);

  logic [31:0]      div_in_ext;
  logic [WIDTH-1:0] div_clamped;

  assign div_in_ext  = 32'(div_in);
  assign div_clamped = clamp_needed(div_in_ext) ? WIDTH'(CLK_DIV_MIN) : div_in;
  assign div_ready   = !pending;

  // A transfer can only happen while nothing is pending, and apply only matters
  // while something is, so the two branches never compete for the same edge.
  always_ff @(posedge original_clk or posedge reset) begin
    if (reset) begin
      shadow_div <= '0;
      pending    <= 1'b0;
    end else if (div_valid && !pending) begin
      shadow_div <= div_clamped;
      pending    <= 1'b1;
    end else if (apply) begin
      pending    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes at period wraps.
// Optional restart input enabled by defining CLK_DIV_SYNC_EN.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = CLK_DIV_WIDTH,
  parameter int DEFAULT_DIV = CLK_DIV_DEFAULT
) (
  input  logic             original_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_ready,
  output logic             new_clk,
  output logic             tick,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] div_last;
  logic [WIDTH-1:0] half;
  logic             wrap;
  logic             pending;
  logic [WIDTH-1:0] shadow_div;

  assign cnt_next = cnt + ONE;
  assign div_last = div_active - ONE;
  // (D+1)>>1 without needing an extra bit for D+1
  assign half     = (div_active >> 1) + {{(WIDTH-1){1'b0}}, div_active[0]};

`ifdef CLK_DIV_SYNC_EN
  assign wrap = sync || (cnt == div_last);
`else
  assign wrap = (cnt == div_last);
`endif

  clk_div_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .original_clk(original_clk),
    .reset       (reset),
    .div_in      (div_in),
    .div_valid   (div_valid),
    .apply       (wrap),
    .div_ready   (div_ready),
    .pending     (pending),
    .shadow_div  (shadow_div)
  );

  // Reset parks the counter one step before the wrap so the first edge starts a period.
  always_ff @(posedge original_clk or posedge reset) begin
    if (reset) begin
      cnt        <= WIDTH'(DEFAULT_DIV - 1);
      div_active <= WIDTH'(DEFAULT_DIV);
      new_clk    <= 1'b0;
      tick       <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      new_clk <= 1'b1;
      tick    <= 1'b1;
      if (pending) begin
        div_active <= shadow_div;
      end
    end else begin
      cnt  <= cnt_next;
      tick <= 1'b0;
      if (cnt_next == half) begin
        new_clk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (sync scenario built when CLK_DIV_SYNC_EN is defined).
module tb_clk_div_prog;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             new_clk;
  logic             tick;
  logic [WIDTH-1:0] div_active;
`ifdef CLK_DIV_SYNC_EN
  logic             sync;
`endif

  int errors = 0;
  int checks = 0;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .original_clk(clk),
    .reset       (reset),
    .div_in      (div_in),
    .div_valid   (div_valid),
`ifdef CLK_DIV_SYNC_EN
    .sync        (sync),
`endif
    .div_ready   (div_ready),
    .new_clk     (new_clk),
    .tick        (tick),
    .div_active  (div_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input logic nc, input logic tk, input logic rdy,
                         input logic [WIDTH-1:0] act, input string tag);
    chk({tag, ".new_clk"},    32'(new_clk),    32'(nc));
    chk({tag, ".tick"},       32'(tick),       32'(tk));
    chk({tag, ".div_ready"},  32'(div_ready),  32'(rdy));
    chk({tag, ".div_active"}, 32'(div_active), 32'(act));
  endtask

  task automatic step(input logic nc, input logic tk, input logic rdy,
                      input logic [WIDTH-1:0] act, input string tag);
    @(posedge clk);
    #1;
    chk_all(nc, tk, rdy, act, tag);
  endtask

  // Patterns are read MSB first: bit n-1 is the first cycle checked.
  task automatic run_pat(input int n, input logic [31:0] nc_pat, input logic [31:0] tk_pat,
                         input logic rdy, input logic [WIDTH-1:0] act, input string tag);
    for (int i = 0; i < n; i++) begin
      step(nc_pat[n-1-i], tk_pat[n-1-i], rdy, act, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    reset     = 1'b1;
    div_in    = '0;
    div_valid = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    sync      = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all(1'b0, 1'b0, 1'b1, 16'd4, "reset");
    reset = 1'b0;

    // Default ratio 4: 1100 repeating, tick at cycles 1, 5, 9
    run_pat(12, 32'b110011001100, 32'b100010001000, 1'b1, 16'd4, "div4");
    step(1'b1, 1'b1, 1'b1, 16'd4, "c13");
    step(1'b1, 1'b0, 1'b1, 16'd4, "c14");

    // Mid-period write of 5
    div_in = 16'd5; div_valid = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'd4, "wr5_xfer");
    div_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd4, "wr5_wait");
    step(1'b1, 1'b1, 1'b1, 16'd5, "wr5_apply");
    run_pat(9, 32'b110011100, 32'b000010000, 1'b1, 16'd5, "div5");
    step(1'b1, 1'b1, 1'b1, 16'd5, "c27");
    step(1'b1, 1'b0, 1'b1, 16'd5, "c28");

    // Write 0 -> clamps to 2
    div_in = 16'd0; div_valid = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd5, "wr0_xfer");
    div_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd5, "wr0_c30");
    step(1'b0, 1'b0, 1'b0, 16'd5, "wr0_c31");
    step(1'b1, 1'b1, 1'b1, 16'd2, "wr0_apply");
    run_pat(6, 32'b010101, 32'b010101, 1'b1, 16'd2, "div2a");

    // Write 1 -> clamps to 2
    div_in = 16'd1; div_valid = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'd2, "wr1_xfer");
    div_valid = 1'b0;
    step(1'b1, 1'b1, 1'b1, 16'd2, "wr1_apply");
    step(1'b0, 1'b0, 1'b1, 16'd2, "div2b_c41");
    step(1'b1, 1'b1, 1'b1, 16'd2, "div2b_c42");
    step(1'b0, 1'b0, 1'b1, 16'd2, "div2b_c43");

    // Transfer on the wrap edge, then hold valid with a different value
    div_in = 16'd3; div_valid = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'd2, "wr3_on_wrap");
    div_in = 16'd7;
    step(1'b0, 1'b0, 1'b0, 16'd2, "wr3_old_period");
    div_valid = 1'b0;
    step(1'b1, 1'b1, 1'b1, 16'd3, "wr3_apply");
    run_pat(6, 32'b101101, 32'b001001, 1'b1, 16'd3, "div3");

    // Pending 9 then reset at cnt = 2
    div_in = 16'd9; div_valid = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd3, "wr9_xfer");
    div_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd3, "wr9_cnt2");
    reset = 1'b1;
    #1;
    chk_all(1'b0, 1'b0, 1'b1, 16'd4, "async_reset");
    @(posedge clk);
    #1;
    chk_all(1'b0, 1'b0, 1'b1, 16'd4, "reset_held");
    reset = 1'b0;
    run_pat(9, 32'b110011001, 32'b100010001, 1'b1, 16'd4, "post_reset");

`ifdef CLK_DIV_SYNC_EN
    div_in = 16'd8; div_valid = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd4, "wr8_xfer");
    div_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd4, "wr8_c11");
    step(1'b0, 1'b0, 1'b0, 16'd4, "wr8_c12");
    step(1'b1, 1'b1, 1'b1, 16'd8, "wr8_apply");
    run_pat(5, 32'b11100, 32'b00000, 1'b1, 16'd8, "div8_pre");
    sync = 1'b1;
    step(1'b1, 1'b1, 1'b1, 16'd8, "sync_wrap");
    sync = 1'b0;
    run_pat(8, 32'b11100001, 32'b00000001, 1'b1, 16'd8, "div8_post");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
